// File: rtl/sid_cmd_queue.sv
// sid_cmd_queue: decodes 2-byte SPI write commands (header, data),
// queues them, and releases one SID register write per CLKen tick.
//   CLK, RST (async, active-high), CLKen (1 MHz enable)
//   spi_data/spi_recv: byte stream in; clr: clears sticky flags
//   WR (one-hot per SID), ADDR, DATAW: register write out
//   level: FIFO occupancy; overflow, proto_err: sticky flags
// Optional: define SID_CMD_TIMEOUT_EN to abandon a half-received
// command after TIMEOUT idle CLK cycles.
module sid_cmd_queue #(
  parameter int NUM_SIDS = 1,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 16,
  parameter int TIMEOUT  = 4095
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLKen,
  input  logic [7:0]               spi_data,
  input  logic                     spi_recv,
  input  logic                     clr,
  output logic [NUM_SIDS-1:0]      WR,
  output logic [ADDR_W-1:0]        ADDR,
  output logic [7:0]               DATAW,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     proto_err
);

  localparam int CHIP_W = $clog2(NUM_SIDS);
  localparam int CW     = (CHIP_W > 0) ? CHIP_W : 1;
  localparam int PW     = $clog2(DEPTH);
  localparam int EW     = CW + ADDR_W + 8;

  typedef enum logic {HDR, DATA} st_t;

  st_t               st;
  logic [CW-1:0]     hdr_chip;
  logic [ADDR_W-1:0] hdr_addr;
  logic [CW-1:0]     in_chip;

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [EW-1:0]     rd;
  logic [CW-1:0]     rd_chip;

  logic push_req;
  logic full;
  logic pop;
  logic push;
  logic ovf_set;
  logic hdr_err;
  logic tmo;

  // With a single SID there are no chip bits in the header.
  generate
    if (NUM_SIDS > 1) begin : g_chip
      assign in_chip = spi_data[ADDR_W+CHIP_W-1:ADDR_W];
    end else begin : g_nochip
      assign in_chip = '0;
    end
  endgenerate

  assign push_req = spi_recv && (st == DATA);
  assign full     = (level == (PW+1)'(DEPTH));
  assign pop      = CLKen && (level != '0);
  // A pop in the same cycle frees the slot, so a full push still fits.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign hdr_err  = spi_recv && (st == HDR) && !spi_data[7];

  assign rd      = mem[rp];
  assign rd_chip = rd[EW-1 -: CW];

`ifdef SID_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;

  assign tmo = (st == DATA) && !spi_recv &&
               (tcnt == TW'(TIMEOUT - 1));

  // Idle counter only runs while waiting for the data byte.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt <= '0;
    end else if (st != DATA || spi_recv) begin
      tcnt <= '0;
    end else if (!tmo) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Storage has no reset; emptiness lives in the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wp] <= {hdr_chip, hdr_addr, spi_data};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st        <= HDR;
      hdr_chip  <= '0;
      hdr_addr  <= '0;
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      WR        <= '0;
      ADDR      <= '0;
      DATAW     <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      unique case (st)
        HDR: begin
          if (spi_recv && spi_data[7]) begin
            hdr_chip <= in_chip;
            hdr_addr <= spi_data[ADDR_W-1:0];
            st       <= DATA;
          end
        end
        DATA: begin
          if (spi_recv || tmo) begin
            st <= HDR;
          end
        end
        default: st <= HDR;
      endcase

      if (push) begin
        wp <= wp + 1'b1;
      end

      WR <= '0;
      if (pop) begin
        rp    <= rp + 1'b1;
        WR    <= NUM_SIDS'(1) << rd_chip;
        ADDR  <= rd[8 +: ADDR_W];
        DATAW <= rd[7:0];
      end

      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      // Setting events win over clr.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end

      if (hdr_err || tmo) begin
        proto_err <= 1'b1;
      end else if (clr) begin
        proto_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sid_cmd_queue.sv
// tb_sid_cmd_queue: directed-vector bench for sid_cmd_queue
// (NUM_SIDS=2, ADDR_W=5, DEPTH=8, TIMEOUT=100).
module tb_sid_cmd_queue;

  logic       CLK;
  logic       RST;
  logic       CLKen;
  logic [7:0] spi_data;
  logic       spi_recv;
  logic       clr;
  logic [1:0] WR;
  logic [4:0] ADDR;
  logic [7:0] DATAW;
  logic [3:0] level;
  logic       overflow;
  logic       proto_err;

  sid_cmd_queue #(
    .NUM_SIDS(2),
    .ADDR_W  (5),
    .DEPTH   (8),
    .TIMEOUT (100)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .CLKen    (CLKen),
    .spi_data (spi_data),
    .spi_recv (spi_recv),
    .clr      (clr),
    .WR       (WR),
    .ADDR     (ADDR),
    .DATAW    (DATAW),
    .level    (level),
    .overflow (overflow),
    .proto_err(proto_err)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int b2b  = 0;
  logic [1:0] prev_wr = '0;
  bit   ck_run = 0;
  int   ck_cnt = 0;

  int         lc[$];
  logic [1:0] lw[$];
  logic [4:0] la[$];
  logic [7:0] ld[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic log_clear();
    lc.delete();
    lw.delete();
    la.delete();
    ld.delete();
  endtask

  // One clock: inputs return to idle, CLKen paced when ck_run,
  // and any WR pulse is logged.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    spi_recv = 1'b0;
    clr      = 1'b0;
    if (ck_run) begin
      CLKen  = (ck_cnt == 11);
      ck_cnt = (ck_cnt == 11) ? 0 : ck_cnt + 1;
    end else begin
      CLKen = 1'b0;
    end
    if (WR != '0) begin
      lc.push_back(cyc);
      lw.push_back(WR);
      la.push_back(ADDR);
      ld.push_back(DATAW);
      if (prev_wr != '0) b2b++;
    end
    prev_wr = WR;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_data = b;
    spi_recv = 1'b1;
    step();
    step();
  endtask

  task automatic send_cmd(input logic [7:0] h, input logic [7:0] d);
    send_byte(h);
    send_byte(d);
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] w,
                         input logic [4:0] a, input logic [7:0] d);
    CLKen = 1'b1;
    step();
    check({tag, "_wr"}, WR, w);
    check({tag, "_addr"}, ADDR, a);
    check({tag, "_data"}, DATAW, d);
    step();
    check({tag, "_wr_off"}, WR, 2'b00);
    check({tag, "_hold"}, DATAW, d);
  endtask

  task automatic run(input int n);
    ck_run = 1;
    ck_cnt = 0;
    for (int i = 0; i < n; i++) step();
    ck_run = 0;
    step();
  endtask

  logic [7:0] ph[5] = '{8'h81, 8'hA2, 8'h83, 8'hA4, 8'h85};
  logic [7:0] pd[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hC5};
  logic [1:0] pw[5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    RST      = 1'b1;
    CLKen    = 1'b0;
    spi_data = '0;
    spi_recv = 1'b0;
    clr      = 1'b0;
    #1;
    check("rst_wr", WR, 0);
    check("rst_addr", ADDR, 0);
    check("rst_data", DATAW, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_perr", proto_err, 0);
    step();
    step();
    RST = 1'b0;
    step();

    // single write to chip 1
    send_cmd(8'hA3, 8'h7F);
    check("single_level1", level, 1);
    pop_chk("single", 2'b10, 5'h03, 8'h7F);
    check("single_level0", level, 0);

    // protocol error then a good command
    send_byte(8'h15);
    check("perr_set", proto_err, 1);
    check("perr_nopush", level, 0);
    send_cmd(8'h81, 8'hFF);
    check("perr_next_level", level, 1);
    pop_chk("perr_next", 2'b01, 5'h01, 8'hFF);
    clr = 1'b1;
    step();
    check("perr_clr", proto_err, 0);
    spi_data = 8'h15;
    spi_recv = 1'b1;
    clr      = 1'b1;
    step();
    check("perr_clr_race", proto_err, 1);
    clr = 1'b1;
    step();
    check("perr_clr2", proto_err, 0);

    // data byte with bit7 set, FSM back in HDR afterwards
    send_cmd(8'h82, 8'h80);
    send_cmd(8'h83, 8'h01);
    check("b7_level", level, 2);
    check("b7_noperr", proto_err, 0);
    pop_chk("b7_a", 2'b01, 5'h02, 8'h80);
    pop_chk("b7_b", 2'b01, 5'h03, 8'h01);

    // pacing: five commands, drained at one per CLKen
    for (int i = 0; i < 5; i++) send_cmd(ph[i], pd[i]);
    check("pace_peak", level, 5);
    log_clear();
    run(70);
    check("pace_count", lc.size(), 5);
    if (lc.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("pace_wr%0d", i), lw[i], pw[i]);
        check($sformatf("pace_addr%0d", i), la[i], i + 1);
        check($sformatf("pace_data%0d", i), ld[i], pd[i]);
        if (i > 0)
          check($sformatf("pace_gap%0d", i), lc[i] - lc[i-1], 12);
      end
    end
    check("pace_level0", level, 0);

    // overflow: nine commands into eight entries
    for (int i = 0; i < 9; i++)
      send_cmd(8'h80 | 8'(i), 8'h10 + 8'(i));
    check("ovf_level", level, 8);
    check("ovf_flag", overflow, 1);
    clr = 1'b1;
    step();
    check("ovf_clr", overflow, 0);
    // push and pop together at full
    send_byte(8'h8A);
    spi_data = 8'h55;
    spi_recv = 1'b1;
    CLKen    = 1'b1;
    step();
    check("full_pp_level", level, 8);
    check("full_pp_ovf", overflow, 0);
    check("full_pp_wr", WR, 2'b01);
    check("full_pp_addr", ADDR, 5'h00);
    check("full_pp_data", DATAW, 8'h10);
    step();
    log_clear();
    run(8 * 12 + 6);
    check("drain_count", lc.size(), 8);
    if (lc.size() == 8) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("drain_addr%0d", i), la[i], i + 1);
        check($sformatf("drain_data%0d", i), ld[i], 8'h11 + 8'(i));
      end
      check("drain_addr7", la[7], 5'h0A);
      check("drain_data7", ld[7], 8'h55);
    end
    check("drain_level0", level, 0);

    // stalled header
    clr = 1'b1;
    step();
    send_byte(8'h84);
    for (int i = 0; i < 150; i++) step();
`ifdef SID_CMD_TIMEOUT_EN
    check("tmo_perr", proto_err, 1);
    send_cmd(8'h84, 8'h10);
`else
    check("wait_perr", proto_err, 0);
    send_byte(8'h10);
`endif
    check("tmo_level", level, 1);
    pop_chk("tmo", 2'b01, 5'h04, 8'h10);
    check("tmo_level0", level, 0);
    clr = 1'b1;
    step();

    // asynchronous reset mid-queue with a header pending
    send_cmd(8'hA6, 8'h66);
    send_cmd(8'h87, 8'h77);
    pop_chk("pre_rst", 2'b10, 5'h06, 8'h66);
    send_byte(8'h89);
    check("pre_rst_level", level, 1);
    #2;
    RST = 1'b1;
    #1;
    check("arst_level", level, 0);
    check("arst_addr", ADDR, 0);
    check("arst_data", DATAW, 0);
    check("arst_wr", WR, 0);
    step();
    RST = 1'b0;
    step();
    send_byte(8'h05);
    check("arst_hdr_gone", level, 0);
    check("arst_perr", proto_err, 1);

    check("wr_b2b", b2b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sid_cmd_queue.md
# sid_cmd_queue

Parametrised SPI command decoder and write queue feeding one or more SID cores. Takes the byte stream from `spi_slave`, decodes two-byte write commands carrying chip index, register address and a full 8-bit data byte, buffers them in a FIFO, and releases at most one register write per SID clock-enable tick so register updates land paced to the 1 MHz SID timebase. It sits between `spi_slave`/`sid_clk` and the SID instances in `top`.

## Interface
- `NUM_SIDS`, 1: number of SID cores; legal 1, 2, 4. `CHIP_W = clog2(NUM_SIDS)`.
- `ADDR_W`, 5: SID register address width. Requires `1 + CHIP_W + ADDR_W <= 8`.
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `TIMEOUT`, 4095: CLK cycles without a byte before a half-received command is abandoned (used only with `SID_CMD_TIMEOUT_EN`).

- `CLK` in 1: system clock, 12 MHz.
- `RST` in 1: asynchronous, active-high reset.
- `CLKen` in 1: SID 1 MHz enable pulse, one CLK wide.
- `spi_data` in 8: received SPI byte, valid when `spi_recv`.
- `spi_recv` in 1: one-cycle byte-received strobe.
- `clr` in 1: clears sticky `overflow`/`proto_err`.
- `WR` out NUM_SIDS: one-hot write strobe per SID.
- `ADDR` out ADDR_W: register address.
- `DATAW` out 8: register write data.
- `level` out clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky, a command was dropped on full FIFO.
- `proto_err` out 1: sticky, a non-header byte arrived in HDR state.

## Operation
- Header byte: bit7=1, bits[ADDR_W+CHIP_W-1:ADDR_W] = chip, bits[ADDR_W-1:0] = addr; unused bits ignored. With `NUM_SIDS=1`, chip = 0.
- Data byte: the next byte after a header, all 8 bits taken verbatim (bit7 may be 1).
- FSM: HDR (reset state) and DATA.
  - HDR, byte with bit7=1: latch chip/addr, go to DATA.
  - HDR, byte with bit7=0: drop byte, set `proto_err`, stay in HDR.
  - DATA, any byte: push {chip, addr, byte}, return to HDR.
- Chip index >= NUM_SIDS (only possible for non-power-of-two, so never): no constraint needed.
- Push when FIFO full and no pop that cycle: command dropped, `overflow` set, FSM still returns to HDR.
- Simultaneous push and pop at full: both happen, no overflow.
- Pop: in any cycle with `CLKen`=1 and FIFO non-empty (registered state), pop one entry.
- `clr` clears sticky flags; `clr` and a setting event in the same cycle leave the flag set.
- FIFO order strictly preserved; no write is reordered across chips.

## Timing
- Reset: FSM=HDR, FIFO empty, `level`=0, `WR`=0, `ADDR`=0, `DATAW`=0, `overflow`=0, `proto_err`=0. Reset mid-command discards the latched header and all queued entries.
- Push: `spi_recv` in cycle M (DATA state) → entry written at edge ending M; `level` increments in M+1.
- Pop: `CLKen` in cycle K with FIFO non-empty → `WR[chip]`=1 for exactly cycle K+1, `ADDR`/`DATAW` valid from K+1 and held until next pop; `level` decrements in K+1.
- Push into empty FIFO in the same cycle as `CLKen`: not popped until the next `CLKen` (12 cycles later).
- Maximum drain rate one write per `CLKen`; `WR` never high two consecutive cycles.
- `spi_recv` strobes are at least 2 cycles apart (SPI byte rate); back-to-back strobes still handled one byte per cycle.

## Configuration
- `SID_CMD_TIMEOUT_EN` defined: a counter runs in DATA state, reset by each `spi_recv`; on reaching `TIMEOUT` cycles with no byte, FSM returns to HDR, header discarded, `proto_err` set. Counter cleared on entry to DATA.
- Not defined: no counter logic; DATA state waits indefinitely for its data byte.

## Test plan
- Single write, NUM_SIDS=2: bytes 0xA3 (chip1, addr 0x03), 0x7F → on next `CLKen` K, `WR`=2'b10 in K+1 only, `ADDR`=0x03, `DATAW`=0x7F, `level` 1→0.
- Pacing: 5 commands sent back-to-back → 5 `WR` pulses exactly 12 CLK apart, in send order, `level` peaks at 5.
- Overflow, DEPTH=4, no `CLKen`: 5 commands → `level`=4, `overflow`=1, 5th discarded; `clr` → `overflow`=0.
- Protocol error: byte 0x15 in HDR → `proto_err`=1, no push; following 0x81,0xFF accepted normally (chip0 addr 1 data 0xFF).
- Data byte with bit7=1: 0x82, 0x80 → write addr 2 data 0x80, FSM back to HDR.
- With `SID_CMD_TIMEOUT_EN`, TIMEOUT=100: header 0x84, 150 idle cycles, then 0x84,0x10 → first header abandoned, `proto_err`=1, exactly one write addr 4 data 0x10; `RST` asserted mid-queue empties FIFO and zeroes all outputs asynchronously.
